spec_add24_sched: RTL

- Shares one 24-bit segmented fast adder (three 8-bit segments plus carry-correction logic) between two requesters.
- Runs the adder's variable-latency protocol: every operation gets a fast pass. A fix pass follows only when the adder raises its correction flag.
- Results return through a valid/ready response port tagged with the requester ID.
- Sits between the two issuing units and the adder datapath. The adder itself stays combinational and external.

---
 rtl/spec_add_pkg.sv | 15 +
 rtl/spec_add24_sched_rr_arb2.sv | 28 ++
 rtl/spec_add24_sched.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/spec_add_pkg.sv
// spec_add_pkg: shared types and constants for the 24-bit segmented-adder scheduler.
`default_nettype none
package spec_add_pkg;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FAST = 2'd1,
      FIX  = 2'd2,
      RESP = 2'd3
   } state_t;

   localparam int SEG_W    = 8;
   localparam int DEF_W    = 24;
   localparam int FIXCNT_W = 3;
endpackage
`default_nettype wire

// File: rtl/spec_add24_sched_rr_arb2.sv
// rr_arb2: two-input round-robin arbiter; the pointer moves to the loser on each advance.
`default_nettype none
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] grant
);
   // ptr names the requester that wins a tie
   logic ptr;

   always_comb begin
      grant = 2'b00;
      if (req[0] && (!req[1] || !ptr))
         grant = 2'b01;
      else if (req[1])
         grant = 2'b10;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ptr <= 1'b0;
      else if (advance)
         ptr <= grant[0];
   end
endmodule
`default_nettype wire

// File: rtl/spec_add24_sched.sv
// spec_add24_sched: shares one external segmented adder between two requesters.
// Optional SPEC_ADD_STATS_EN adds saturating stat_ops / stat_fixes counters.
`default_nettype none
module spec_add24_sched
   import spec_add_pkg::*;
#(
   parameter int W          = DEF_W,
   parameter int FIX_CYCLES = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [W-1:0] req0_a,
   input  logic [W-1:0] req0_b,
   input  logic         req0_c0,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [W-1:0] req1_a,
   input  logic [W-1:0] req1_b,
   input  logic         req1_c0,
   output logic         res_valid,
   input  logic         res_ready,
   output logic [W-1:0] res_s,
   output logic         res_c,
   output logic         res_id,
   output logic         res_fixed,
   output logic [W-1:0] add_a,
   output logic [W-1:0] add_b,
   output logic         add_c0,
   output logic         add_fix,
   input  logic [W-1:0] add_s,
   input  logic         add_c24,
   input  logic         add_sx
`ifdef SPEC_ADD_STATS_EN
   ,
   output logic [15:0]  stat_ops,
   output logic [15:0]  stat_fixes
`endif
);
   localparam logic [FIXCNT_W-1:0] FIX_LAST = FIXCNT_W'(FIX_CYCLES - 1);

   if (W % SEG_W != 0) begin : g_bad_width
      $error("W must be a multiple of SEG_W");
   end

   state_t              state;
   logic [FIXCNT_W-1:0] fix_cnt;
   logic                op_id;
   logic [1:0]          grant;
   logic                req_en;
   logic                accept;
   logic                res_hs;

   // Overlap is one deep: a new operation may only start as the held result leaves
   assign req_en     = (state == IDLE) || ((state == RESP) && res_ready);
   assign req0_ready = req_en & grant[0];
   assign req1_ready = req_en & grant[1];
   assign accept     = req0_ready | req1_ready;
   assign res_hs     = res_valid & res_ready;

   rr_arb2 u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     ({req1_valid, req0_valid}),
      .advance (accept),
      .grant   (grant)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         fix_cnt   <= '0;
         op_id     <= 1'b0;
         add_a     <= '0;
         add_b     <= '0;
         add_c0    <= 1'b0;
         add_fix   <= 1'b0;
         res_valid <= 1'b0;
         res_s     <= '0;
         res_c     <= 1'b0;
         res_id    <= 1'b0;
         res_fixed <= 1'b0;
      end else begin
         if (accept) begin
            add_a  <= grant[1] ? req1_a  : req0_a;
            add_b  <= grant[1] ? req1_b  : req0_b;
            add_c0 <= grant[1] ? req1_c0 : req0_c0;
            op_id  <= grant[1];
         end
         case (state)
            IDLE: begin
               if (accept)
                  state <= FAST;
            end
            FAST: begin
               if (!add_sx) begin
                  res_s     <= add_s;
                  res_c     <= add_c24;
                  res_id    <= op_id;
                  res_fixed <= 1'b0;
                  res_valid <= 1'b1;
                  state     <= RESP;
               end else begin
                  add_fix <= 1'b1;
                  fix_cnt <= '0;
                  state   <= FIX;
               end
            end
            FIX: begin
               if (fix_cnt == FIX_LAST) begin
                  res_s     <= add_s;
                  res_c     <= add_c24;
                  res_id    <= op_id;
                  res_fixed <= 1'b1;
                  res_valid <= 1'b1;
                  add_fix   <= 1'b0;
                  state     <= RESP;
               end else begin
                  fix_cnt <= fix_cnt + FIXCNT_W'(1);
               end
            end
            RESP: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  state     <= accept ? FAST : IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef SPEC_ADD_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_ops   <= '0;
         stat_fixes <= '0;
      end else if (res_hs) begin
         if (stat_ops != 16'hFFFF)
            stat_ops <= stat_ops + 16'd1;
         if (res_fixed && (stat_fixes != 16'hFFFF))
            stat_fixes <= stat_fixes + 16'd1;
      end
   end
`else
   logic unused_hs;
   assign unused_hs = res_hs;
`endif
endmodule
`default_nettype wire
